// File: rtl/teclado_debounce.sv
// teclado_debounce
//    Front end for the 12-key piano keyboard. Synchronises the raw key pins,
//    debounces them as one 12-bit vector and hands the datapath a clean
//    one-hot (or all-zero) key vector with single-cycle press/release strobes.
//    Chords are refused: any time more than one key is seen, the block parks
//    in BLOQUEADO until every key is released.
//
// Ports
//    clock        system clock, rising edge
//    reset        asynchronous reset, active low
//    teclas_raw   raw key levels from the pins, bit i = note i
//    botoes       debounced one-hot key vector (or zero) to the datapath
//    pressionado  one-cycle pulse when a single key is accepted
//    solto        one-cycle pulse when the accepted key goes away
//    multiplas    high while in BLOQUEADO
//    db_estado    current FSM state (debug)
//
// state     | meaning
// ----------+---------------------------------------------------------
// OCIOSO    | no key accepted, waiting for exactly one debounced key
// TECLA     | one key accepted and driven on botoes
// BLOQUEADO | more than one key seen; wait for all keys released
module teclado_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit ATIVO_BAIXO     = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] teclas_raw,
   output logic [11:0] botoes,
   output logic        pressionado,
   output logic        solto,
   output logic        multiplas,
   output logic [1:0]  db_estado
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ACC = CW'(DEBOUNCE_CYCLES - 2);

   typedef enum logic [1:0] {
      OCIOSO    = 2'b00,
      TECLA     = 2'b01,
      BLOQUEADO = 2'b10
   } estado_t;

   logic [11:0]   in_cond;
   logic [11:0]   sinc_meta;
   logic [11:0]   sinc;
   logic [11:0]   sinc_ant;
   logic [CW-1:0] cnt;
   logic [11:0]   deb;
   logic          deb_um_bit;

   estado_t       estado, estado_n;
   logic [11:0]   tecla, tecla_n;
   logic [11:0]   botoes_n;
   logic          pressionado_n;
   logic          solto_n;
   logic          multiplas_n;

   assign in_cond = ATIVO_BAIXO ? ~teclas_raw : teclas_raw;

   // cnt restarts on the edge that sees sinc differ from sinc_ant, so that
   // edge's sample is already the first one of the new run. Accepting when
   // cnt reaches DEBOUNCE_CYCLES-2 therefore means sinc has held the same
   // value for DEBOUNCE_CYCLES consecutive samples.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sinc_meta <= '0;
         sinc      <= '0;
         sinc_ant  <= '0;
         cnt       <= '0;
         deb       <= '0;
      end else begin
         sinc_meta <= in_cond;
         sinc      <= sinc_meta;
         sinc_ant  <= sinc;
         if (sinc != sinc_ant) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
         end
         if ((sinc == sinc_ant) && (cnt == CNT_ACC)) begin
            deb <= sinc;
         end
      end
   end

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign deb_um_bit = (deb != '0) && ((deb & (deb - 12'd1)) == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado      <= OCIOSO;
         tecla       <= '0;
         botoes      <= '0;
         pressionado <= 1'b0;
         solto       <= 1'b0;
         multiplas   <= 1'b0;
      end else begin
         estado      <= estado_n;
         tecla       <= tecla_n;
         botoes      <= botoes_n;
         pressionado <= pressionado_n;
         solto       <= solto_n;
         multiplas   <= multiplas_n;
      end
   end

   always_comb begin
      estado_n      = estado;
      tecla_n       = tecla;
      pressionado_n = 1'b0;
      solto_n       = 1'b0;
      unique case (estado)
         OCIOSO: begin
            if (deb_um_bit) begin
               estado_n      = TECLA;
               tecla_n       = deb;
               pressionado_n = 1'b1;
            end else if (deb != '0) begin
               estado_n = BLOQUEADO;
            end
         end
         TECLA: begin
            if (deb == '0) begin
               estado_n = OCIOSO;
               solto_n  = 1'b1;
            end else if (deb != tecla) begin
               // key added or swapped without a gap: treat as a chord
               estado_n = BLOQUEADO;
               solto_n  = 1'b1;
            end
         end
         BLOQUEADO: begin
            if (deb == '0) begin
               estado_n = OCIOSO;
            end
         end
         default: begin
            estado_n = OCIOSO;
         end
      endcase
      botoes_n    = (estado_n == TECLA) ? tecla_n : '0;
      multiplas_n = (estado_n == BLOQUEADO);
   end

   assign db_estado = estado;

endmodule

// File: tb/tb_teclado_debounce.sv
module tb_teclado_debounce;

   localparam int DEB = 4;
   localparam bit AB  = 1'b1;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] teclas_raw = 12'hFFF;
   logic [11:0] botoes;
   logic        pressionado;
   logic        solto;
   logic        multiplas;
   logic [1:0]  db_estado;

   int total = 0;
   int bad   = 0;

   teclado_debounce #(
      .DEBOUNCE_CYCLES(DEB),
      .ATIVO_BAIXO    (AB)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .teclas_raw (teclas_raw),
      .botoes     (botoes),
      .pressionado(pressionado),
      .solto      (solto),
      .multiplas  (multiplas),
      .db_estado  (db_estado)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Pins pass a 2-sample delay line; the debounced value becomes a sample
   // once that sample has been seen DEB times in a row. Key rules act on the
   // debounced value one edge later.
   logic [11:0] m_s1 = '0, m_s2 = '0, m_prev = '0, m_deb = '0, m_tecla = '0;
   logic [11:0] m_botoes = '0, m_deb_old;
   int          m_run = 1;
   int          m_mode = 0;
   logic        m_p = 1'b0, m_s = 1'b0, m_m = 1'b0;

   initial begin
      forever begin
         @(posedge clock or negedge reset);
         if (!reset) begin
            m_s1 = '0; m_s2 = '0; m_prev = '0; m_deb = '0; m_tecla = '0;
            m_botoes = '0; m_run = 1; m_mode = 0; m_p = 0; m_s = 0; m_m = 0;
         end else begin
            m_deb_old = m_deb;
            m_p = 0;
            m_s = 0;
            case (m_mode)
               0: begin
                  if ($countones(m_deb_old) == 1) begin
                     m_mode = 1; m_tecla = m_deb_old; m_p = 1;
                  end else if ($countones(m_deb_old) >= 2) begin
                     m_mode = 2;
                  end
               end
               1: begin
                  if (m_deb_old == 0) begin
                     m_mode = 0; m_s = 1;
                  end else if (m_deb_old != m_tecla) begin
                     m_mode = 2; m_s = 1;
                  end
               end
               default: begin
                  if (m_deb_old == 0) m_mode = 0;
               end
            endcase
            m_botoes = (m_mode == 1) ? m_tecla : 12'h000;
            m_m      = (m_mode == 2);
            if (m_s2 == m_prev) begin
               if (m_run < 1000) m_run++;
            end else begin
               m_run = 1;
            end
            if (m_run >= DEB) m_deb = m_s2;
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = AB ? ~teclas_raw : teclas_raw;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clock);
         chk("botoes", 32'(botoes), 32'(m_botoes));
         chk("pressionado", 32'(pressionado), 32'(m_p));
         chk("solto", 32'(solto), 32'(m_s));
         chk("multiplas", 32'(multiplas), 32'(m_m));
         chk("db_estado", 32'(db_estado), 32'(m_mode));
         chk("pulse_excl", 32'(pressionado & solto), 32'(0));
         chk("onehot", 32'($countones(botoes) <= 1), 32'(1));
      end
   end

   // Change the pins between edges, then check the output exactly
   // DEB+3 edges later (and that it had not moved one edge earlier).
   task automatic apply_and_time(input logic [11:0] raw_v, input logic [11:0] b_before,
                                 input logic [11:0] b_after, input logic p_exp,
                                 input logic s_exp, input string nm);
      @(negedge clock); #1;
      teclas_raw = raw_v;
      repeat (DEB + 2) @(posedge clock);
      #1;
      chk({nm, "_pre"}, 32'(botoes), 32'(b_before));
      @(posedge clock); #1;
      chk({nm, "_botoes"}, 32'(botoes), 32'(b_after));
      chk({nm, "_model"}, 32'(m_botoes), 32'(b_after));
      chk({nm, "_press"}, 32'(pressionado), 32'(p_exp));
      chk({nm, "_solto"}, 32'(solto), 32'(s_exp));
      @(posedge clock); #1;
      chk({nm, "_press_end"}, 32'(pressionado), 32'(0));
      chk({nm, "_solto_end"}, 32'(solto), 32'(0));
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   int          kind, hold, a, b;
   logic [11:0] v;

   initial begin
      // reset and idle
      teclas_raw = 12'hFFF;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      #1 reset = 1'b1;
      wait_edges(10);
      chk("idle_botoes", 32'(botoes), 32'(0));
      chk("idle_press", 32'(pressionado), 32'(0));
      chk("idle_solto", 32'(solto), 32'(0));
      chk("idle_mult", 32'(multiplas), 32'(0));
      chk("idle_estado", 32'(db_estado), 32'(0));

      // clean press / release of key 5
      apply_and_time(12'hFDF, 12'h000, 12'h020, 1'b1, 1'b0, "k5_press");
      apply_and_time(12'hFFF, 12'h020, 12'h000, 1'b0, 1'b1, "k5_rel");
      wait_edges(4);

      // bounce on key 3
      for (int i = 0; i < 10; i++) begin
         @(negedge clock); #1;
         teclas_raw[3] = ~teclas_raw[3];
         repeat (2) begin
            @(posedge clock); #1;
            chk("bounce_botoes", 32'(botoes), 32'(0));
         end
      end
      apply_and_time(12'hFF7, 12'h000, 12'h008, 1'b1, 1'b0, "k3_press");
      apply_and_time(12'hFFF, 12'h008, 12'h000, 1'b0, 1'b1, "k3_rel");
      wait_edges(4);

      // keys 0 and 11 together
      @(negedge clock); #1 teclas_raw = 12'h7FE;
      wait_edges(DEB + 2);
      chk("chord_pre_estado", 32'(db_estado), 32'(0));
      wait_edges(1);
      chk("chord_mult", 32'(multiplas), 32'(1));
      chk("chord_estado", 32'(db_estado), 32'(2));
      chk("chord_botoes", 32'(botoes), 32'(0));
      chk("chord_press", 32'(pressionado), 32'(0));
      @(negedge clock); #1 teclas_raw = 12'hFFF;
      wait_edges(DEB + 2);
      chk("chord_rel_pre", 32'(db_estado), 32'(2));
      wait_edges(1);
      chk("chord_rel_mult", 32'(multiplas), 32'(0));
      chk("chord_rel_estado", 32'(db_estado), 32'(0));

      // key 2 held, key 7 added
      apply_and_time(12'hFFB, 12'h000, 12'h004, 1'b1, 1'b0, "k2_press");
      @(negedge clock); #1 teclas_raw = 12'hF7B;
      wait_edges(DEB + 2);
      chk("add_pre_botoes", 32'(botoes), 32'(12'h004));
      wait_edges(1);
      chk("add_solto", 32'(solto), 32'(1));
      chk("add_botoes", 32'(botoes), 32'(0));
      chk("add_mult", 32'(multiplas), 32'(1));
      chk("add_estado", 32'(db_estado), 32'(2));
      @(negedge clock); #1 teclas_raw = 12'hF7F;
      wait_edges(12);
      chk("add_hold_estado", 32'(db_estado), 32'(2));
      chk("add_hold_mult", 32'(multiplas), 32'(1));
      @(negedge clock); #1 teclas_raw = 12'hFFF;
      wait_edges(DEB + 3);
      chk("add_rel_estado", 32'(db_estado), 32'(0));
      chk("add_rel_mult", 32'(multiplas), 32'(0));

      // asynchronous reset while key 4 is held
      apply_and_time(12'hFEF, 12'h000, 12'h010, 1'b1, 1'b0, "k4_press");
      wait_edges(2);
      @(negedge clock); #2;
      reset = 1'b0;
      #1;
      chk("rst_async_botoes", 32'(botoes), 32'(0));
      chk("rst_async_estado", 32'(db_estado), 32'(0));
      chk("rst_async_press", 32'(pressionado), 32'(0));
      @(negedge clock);
      @(negedge clock); #1;
      reset = 1'b1;
      for (int i = 0; i < DEB + 2; i++) begin
         @(posedge clock); #1;
         chk("rst_fresh_wait", 32'(botoes), 32'(0));
      end
      @(posedge clock); #1;
      chk("rst_fresh_botoes", 32'(botoes), 32'(12'h010));
      chk("rst_fresh_press", 32'(pressionado), 32'(1));
      @(negedge clock); #1 teclas_raw = 12'hFFF;
      wait_edges(12);

      // randomized traffic checked by the model
      for (int k = 0; k < 220; k++) begin
         kind = $urandom_range(0, 9);
         hold = $urandom_range(1, 12);
         @(negedge clock); #1;
         case (kind)
            0, 1, 2, 3: begin
               v = 12'h001 << $urandom_range(0, 11);
               teclas_raw = ~v;
            end
            4, 5: teclas_raw = 12'hFFF;
            6: begin
               a = $urandom_range(0, 11);
               b = $urandom_range(0, 11);
               v = (12'h001 << a) | (12'h001 << b);
               teclas_raw = ~v;
            end
            7: begin
               for (int j = 0; j < hold; j++) begin
                  teclas_raw = 12'($urandom);
                  @(negedge clock); #1;
               end
            end
            8: begin
               reset = 1'b0;
               @(negedge clock); #1;
               reset = 1'b1;
            end
            default: begin
               v = 12'h001 << $urandom_range(0, 11);
               teclas_raw = ~v;
               repeat (DEB + 4) @(negedge clock);
               #1;
               v = 12'h001 << $urandom_range(0, 11);
               teclas_raw = ~v;
            end
         endcase
         repeat (hold) @(negedge clock);
      end

      @(negedge clock); #1 teclas_raw = 12'hFFF;
      wait_edges(20);
      chk("final_estado", 32'(db_estado), 32'(0));
      chk("final_botoes", 32'(botoes), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
